pooling_frame_controller: RTL
=============================

Name: pooling_frame_controller

Overview:
Sequences one drawn-digit inference pass over the shared 1-bit frame-buffer RAM.
- Arbitrates RAM access between the drawing writer, an internal clear engine and the average pooling engine.
- Starts the pooling engine, waits for its done, then holds the pooled result for the classifier until acknowledged.
- Sits between the touch/draw front end, the frame-buffer RAM, the average pooling block and the network input stage.

Parameters:
- FRAME_SIDE, 112, side length of the square input frame in pixels.
- PIXELS, FRAME_SIDE**2, number of frame-buffer locations.
- ADDR_WIDTH, $clog2(PIXELS), RAM address width.
- TIMEOUT_CYCLES, 262143, maximum POOL_RUN cycles; only used when the optional feature is compiled in.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  global enable; when low, state, counters and outputs hold.
- draw_valid  in  1  draw write request.
- draw_addr  in  ADDR_WIDTH  draw write address.
- draw_pixel  in  1  draw write data.
- draw_ready  out  1  draw write accepted this cycle.
- clear_req  in  1  level request to zero the frame.
- classify_req  in  1  level request to run pooling.
- pool_addr  in  ADDR_WIDTH  read address from the pooling engine.
- pool_start  out  1  one-cycle start pulse to the pooling engine.
- pool_done  in  1  done pulse from the pooling engine.
- ram_addr  out  ADDR_WIDTH  muxed RAM address.
- ram_wdata  out  1  RAM write data.
- ram_we  out  1  RAM write enable.
- busy  out  1  high whenever state is not IDLE.
- result_valid  out  1  pooled output is stable and ready to consume.
- result_ack  in  1  classifier has consumed the result.
- pass_count  out  8  completed classification passes; wraps 255 to 0.
- timeout_err  out  1  sticky pooling timeout flag (optional feature).

Behaviour:
- Reset (asynchronous) forces:
  - state IDLE; clear counter, timeout counter and pass_count to 0.
  - pool_start 0, result_valid 0, timeout_err 0, ram_we 0.
- en low: no state transition, no counter change, ram_we forced to 0, pool_start forced to 0. en is the only clock qualifier.
- States: IDLE, CLEAR, POOL_START, POOL_RUN, RESULT. Outputs are a Moore decode of state except ram_we and draw_ready.
- IDLE:
  - draw_ready = en.
  - ram_addr = draw_addr, ram_wdata = draw_pixel, ram_we = draw_valid & en.
  - clear_req has priority over classify_req. If both are high in the same cycle, go to CLEAR; classify_req is not latched.
  - classify_req alone goes to POOL_START.
  - A draw write in the same cycle as a request is still performed.
- CLEAR:
  - ram_addr = clear counter, ram_wdata = 0, ram_we = en.
  - Counter increments on each enabled cycle, 0 to PIXELS-1.
  - At PIXELS-1: write the last location, reset the counter, go to IDLE. Total PIXELS enabled cycles.
  - draw_ready = 0.
- POOL_START:
  - pool_start = 1 for exactly one enabled cycle; ram_addr = pool_addr; ram_we = 0. Then go to POOL_RUN.
  - Latency: classify_req sampled in IDLE at cycle t gives pool_start high during cycle t+1.
- POOL_RUN:
  - ram_addr = pool_addr; ram_we = 0; draw_ready = 0.
  - pool_done goes to RESULT; pass_count increments on the same edge.
  - A pool_done arriving in any other state is ignored.
- RESULT:
  - result_valid = 1; RAM muxed to pool_addr, read-only; draw_ready = 0.
  - result_ack goes to IDLE; result_valid drops on the next cycle.
  - clear_req and classify_req are ignored here.
- Async reset mid-CLEAR or mid-POOL_RUN aborts immediately. A partial clear is not resumed. The pooling engine is reset by the same reset net.

Optional Feature:
Macro POOL_TIMEOUT_EN.
- Defined:
  - A timeout counter runs in POOL_RUN on enabled cycles and is cleared on entry to POOL_RUN.
  - When it reaches TIMEOUT_CYCLES without pool_done: set timeout_err (sticky until reset), go to IDLE, do not increment pass_count.
  - timeout_err is also cleared on entry to CLEAR.
- Not defined: no timeout counter; POOL_RUN waits indefinitely; timeout_err tied to 0.

Test Plan:
1. Reset, then draw_valid=1, draw_addr=100, draw_pixel=1 in IDLE -> ram_we=1, ram_addr=100 the same cycle; draw_ready=1; busy=0.
2. clear_req pulse (FRAME_SIDE=4, PIXELS=16) -> 16 consecutive ram_we cycles, addresses 0..15, ram_wdata=0; busy low on the 17th cycle; draw_ready=0 throughout the clear.
3. clear_req and classify_req high in the same cycle -> CLEAR runs; no pool_start seen for the whole clear.
4. classify_req, then pool_done 50 cycles after pool_start -> pool_start high for 1 cycle; result_valid high until result_ack; pass_count 0 to 1; a draw_valid during RESULT gives no ram_we.
5. en held low for 5 cycles mid-CLEAR at address 7 -> address stays 7 with ram_we=0; the clear resumes at 7 when en returns; 16 writes in total.
6. With POOL_TIMEOUT_EN and TIMEOUT_CYCLES=20, no pool_done -> timeout_err=1 after 20 POOL_RUN cycles, return to IDLE, pass_count unchanged; a later clear_req clears timeout_err.

Source files
------------

// File: rtl/pooling_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : pooling_frame_controller
// Description : Sequences one drawn-digit inference pass over the shared
//               1-bit frame-buffer RAM. Arbitrates RAM access between the
//               drawing writer, an internal clear engine and the average
//               pooling engine, then holds the pooled result for the
//               classifier until it is acknowledged.
//               Optional build macro POOL_TIMEOUT_EN adds a POOL_RUN
//               watchdog with a sticky timeout_err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pooling_frame_controller #(
   parameter int FRAME_SIDE     = 112,
   parameter int PIXELS         = FRAME_SIDE * FRAME_SIDE,
   parameter int ADDR_WIDTH     = $clog2(PIXELS),
   parameter int TIMEOUT_CYCLES = 262143
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  draw_valid,
   input  logic [ADDR_WIDTH-1:0] draw_addr,
   input  logic                  draw_pixel,
   output logic                  draw_ready,
   input  logic                  clear_req,
   input  logic                  classify_req,
   input  logic [ADDR_WIDTH-1:0] pool_addr,
   output logic                  pool_start,
   input  logic                  pool_done,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_wdata,
   output logic                  ram_we,
   output logic                  busy,
   output logic                  result_valid,
   input  logic                  result_ack,
   output logic [7:0]            pass_count,
   output logic                  timeout_err
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_CLEAR      = 3'd1;
   localparam logic [2:0] ST_POOL_START = 3'd2;
   localparam logic [2:0] ST_POOL_RUN   = 3'd3;
   localparam logic [2:0] ST_RESULT     = 3'd4;

   localparam logic [ADDR_WIDTH-1:0] C_CLR_LAST = ADDR_WIDTH'(PIXELS - 1);
   localparam logic [ADDR_WIDTH-1:0] C_CLR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [2:0]            state_q,      state_d;
   logic [ADDR_WIDTH-1:0] clr_cnt_q,    clr_cnt_d;
   logic [7:0]            pass_count_q, pass_count_d;

`ifdef POOL_TIMEOUT_EN
   localparam int                  TO_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_WIDTH-1:0] C_TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_WIDTH-1:0] C_TO_ONE  = {{(TO_WIDTH-1){1'b0}}, 1'b1};

   logic [TO_WIDTH-1:0] to_cnt_q,      to_cnt_d;
   logic                timeout_err_q, timeout_err_d;
`else
   // The timeout length only matters when the watchdog is built in.
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
   end
`endif

   // Next-state, clear counter, pass counter and watchdog update; all held when en is low
   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      pass_count_d = pass_count_q;
`ifdef POOL_TIMEOUT_EN
      to_cnt_d      = to_cnt_q;
      timeout_err_d = timeout_err_q;
`endif
      if (en) begin
         case (state_q)
            ST_IDLE: begin
               // Clear wins over classify; a simultaneous classify is dropped.
               if (clear_req) begin
                  state_d   = ST_CLEAR;
                  clr_cnt_d = '0;
`ifdef POOL_TIMEOUT_EN
                  timeout_err_d = 1'b0;
`endif
               end else if (classify_req) begin
                  state_d = ST_POOL_START;
               end
            end
            ST_CLEAR: begin
               if (clr_cnt_q == C_CLR_LAST) begin
                  clr_cnt_d = '0;
                  state_d   = ST_IDLE;
               end else begin
                  clr_cnt_d = clr_cnt_q + C_CLR_ONE;
               end
            end
            ST_POOL_START: begin
               state_d = ST_POOL_RUN;
`ifdef POOL_TIMEOUT_EN
               to_cnt_d = '0;
`endif
            end
            ST_POOL_RUN: begin
               if (pool_done) begin
                  state_d      = ST_RESULT;
                  pass_count_d = pass_count_q + 8'd1;
`ifdef POOL_TIMEOUT_EN
               end else if (to_cnt_q == C_TO_LAST) begin
                  // Pooling engine never answered: abandon the pass.
                  timeout_err_d = 1'b1;
                  state_d       = ST_IDLE;
               end else begin
                  to_cnt_d = to_cnt_q + C_TO_ONE;
`endif
               end
            end
            ST_RESULT: begin
               if (result_ack) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and counter registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         clr_cnt_q    <= '0;
         pass_count_q <= 8'd0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         pass_count_q <= pass_count_d;
      end
   end

`ifdef POOL_TIMEOUT_EN
   // Watchdog counter and sticky timeout flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         to_cnt_q      <= to_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   // RAM mux and handshake decode; write strobes and start pulse are gated by en
   always_comb begin
      ram_addr     = pool_addr;
      ram_wdata    = 1'b0;
      ram_we       = 1'b0;
      draw_ready   = 1'b0;
      pool_start   = 1'b0;
      result_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ram_addr   = draw_addr;
            ram_wdata  = draw_pixel;
            ram_we     = draw_valid & en;
            draw_ready = en;
         end
         ST_CLEAR: begin
            ram_addr  = clr_cnt_q;
            ram_wdata = 1'b0;
            ram_we    = en;
         end
         ST_POOL_START: begin
            pool_start = en;
         end
         ST_RESULT: begin
            result_valid = 1'b1;
         end
         default: begin
            ram_addr = pool_addr;
         end
      endcase
   end

   assign busy       = (state_q != ST_IDLE);
   assign pass_count = pass_count_q;

endmodule
`default_nettype wire
